scr_mover: RTL and testbench

Scratch-RAM block mover for the RAT MCU: an initiator that drives the scratch RAM's address, write-data and write-enable inputs and consumes its combinational read data. It performs a fill (constant into N consecutive words) or a forward copy (N words from source to destination) without CPU involvement. Its SCR_* outputs feed the scratch-RAM input mux, and the mux selects this block while BUSY is high.

---
 rtl/scr_mover_pkg.sv | 20 ++
 rtl/scr_mover.sv | 122 ++++++++++++
 tb/tb_scr_mover.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr_mover_pkg.sv
// Shared widths and enums for the scratch-RAM block mover.
package scr_mover_pkg;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RD,
    WR,
    FIN
  } state_t;

  typedef enum logic {
    MODE_FILL = 1'b0,
    MODE_COPY = 1'b1
  } mode_t;

endpackage

// File: rtl/scr_mover.sv
// Scratch-RAM block mover: fill or forward copy, driving the scratch RAM directly.
// Optional running checksum of written words when SCR_MOVER_CHKSUM_EN is defined.
module scr_mover
  import scr_mover_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              MODE,
  input  logic [ADDR_W-1:0] SRC,
  input  logic [ADDR_W-1:0] DST,
  input  logic [ADDR_W-1:0] LEN,
  input  logic [DATA_W-1:0] FILL_VAL,
  input  logic [DATA_W-1:0] SCR_DATA_OUT,
  output logic [ADDR_W-1:0] SCR_ADDR,
  output logic [DATA_W-1:0] SCR_DIN,
  output logic              SCR_WE,
  output logic              BUSY,
  output logic              DONE
`ifdef SCR_MOVER_CHKSUM_EN
  ,
  output logic [DATA_W-1:0] CHKSUM
`endif
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_ptr, dst_ptr, count;
  logic [DATA_W-1:0] fill_q, data_q;
  logic              accept;

  assign accept = (state == IDLE) && START;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs decode from state and registers only; START merely steers the next state.
  always_comb begin
    state_nxt = state;
    SCR_ADDR  = '0;
    SCR_DIN   = '0;
    SCR_WE    = 1'b0;
    BUSY      = 1'b1;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (START) begin
          if (LEN == '0)                         state_nxt = FIN;
          else if (mode_t'(MODE) == MODE_COPY)   state_nxt = RD;
          else                                   state_nxt = FILL;
        end
      end
      FILL: begin
        SCR_ADDR = dst_ptr;
        SCR_DIN  = fill_q;
        SCR_WE   = 1'b1;
        if (count == ADDR_W'(1)) state_nxt = FIN;
      end
      RD: begin
        SCR_ADDR  = src_ptr;
        state_nxt = WR;
      end
      WR: begin
        SCR_ADDR  = dst_ptr;
        SCR_DIN   = data_q;
        SCR_WE    = 1'b1;
        state_nxt = (count == ADDR_W'(1)) ? FIN : RD;
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      count   <= '0;
      fill_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: if (START) begin
          src_ptr <= SRC;
          dst_ptr <= DST;
          count   <= LEN;
          fill_q  <= FILL_VAL;
        end
        FILL: begin
          dst_ptr <= dst_ptr + 1'b1;
          count   <= count - 1'b1;
        end
        RD: begin
          data_q  <= SCR_DATA_OUT;
          src_ptr <= src_ptr + 1'b1;
        end
        WR: begin
          dst_ptr <= dst_ptr + 1'b1;
          count   <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SCR_MOVER_CHKSUM_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      CHKSUM <= '0;
    else if (accept) CHKSUM <= '0;
    else if (SCR_WE) CHKSUM <= CHKSUM + SCR_DIN;
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_scr_mover.sv
// Self-checking bench for scr_mover: RAM model plus a write scoreboard.
module tb_scr_mover;
  import scr_mover_pkg::*;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              START;
  logic              MODE;
  logic [ADDR_W-1:0] SRC, DST, LEN;
  logic [DATA_W-1:0] FILL_VAL;
  logic [DATA_W-1:0] SCR_DATA_OUT;
  logic [ADDR_W-1:0] SCR_ADDR;
  logic [DATA_W-1:0] SCR_DIN;
  logic              SCR_WE, BUSY, DONE;
`ifdef SCR_MOVER_CHKSUM_EN
  logic [DATA_W-1:0] CHKSUM;
`endif

  logic [DATA_W-1:0] ram [256];
  logic [ADDR_W+DATA_W-1:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  assign SCR_DATA_OUT = ram[SCR_ADDR];

  always @(posedge CLK) if (SCR_WE) ram[SCR_ADDR] <= SCR_DIN;

  scr_mover dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .MODE(MODE),
    .SRC(SRC), .DST(DST), .LEN(LEN), .FILL_VAL(FILL_VAL),
    .SCR_DATA_OUT(SCR_DATA_OUT), .SCR_ADDR(SCR_ADDR), .SCR_DIN(SCR_DIN),
    .SCR_WE(SCR_WE), .BUSY(BUSY), .DONE(DONE)
`ifdef SCR_MOVER_CHKSUM_EN
    , .CHKSUM(CHKSUM)
`endif
  );

  // Drive a request at a negedge; returns at the negedge of cycle 1 after acceptance.
  task automatic start_op(input logic m, input logic [ADDR_W-1:0] s, d, n,
                          input logic [DATA_W-1:0] fv);
    MODE = m; SRC = s; DST = d; LEN = n; FILL_VAL = fv; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; START = 1'b1; MODE = 1'b0; SRC = '0; DST = 8'h33; LEN = 8'd5; FILL_VAL = 10'h2AA;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({BUSY, DONE, SCR_WE, SCR_ADDR, SCR_DIN} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got busy=%b done=%b we=%b addr=%h din=%h want all 0",
               BUSY, DONE, SCR_WE, SCR_ADDR, SCR_DIN);
    end
`ifdef SCR_MOVER_CHKSUM_EN
    vectors++;
    if (CHKSUM !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_chksum got %h want 000", CHKSUM);
    end
`endif
    START = 1'b0;
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_fill;
    int done_cyc = 0;
    logic [ADDR_W+DATA_W-1:0] e;
    for (int i = 0; i < 4; i++) exp_q.push_back({8'hF0 + 8'(i), 10'h155});
    start_op(1'b0, 8'h00, 8'hF0, 8'd4, 10'h155);
    for (int c = 1; c <= 20; c++) begin
      if (SCR_WE) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL fill_extra_write got addr=%h din=%h want none", SCR_ADDR, SCR_DIN);
        end else begin
          e = exp_q.pop_front();
          if ({SCR_ADDR, SCR_DIN} !== e) begin
            miscompares++;
            $display("[TB] FAIL fill_write got %h/%h want %h/%h", SCR_ADDR, SCR_DIN, e[17:10], e[9:0]);
          end
        end
      end
      if (DONE) begin done_cyc = c; break; end
      @(negedge CLK);
    end
    vectors++;
    if (done_cyc != 5) begin
      miscompares++;
      $display("[TB] FAIL fill_done_cycle got %0d want 5", done_cyc);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL fill_missing_writes got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge CLK);
    vectors++;
    if (BUSY !== 1'b0 || ram[8'hF3] !== 10'h155) begin
      miscompares++;
      $display("[TB] FAIL fill_end got busy=%b ram[F3]=%h want 0/155", BUSY, ram[8'hF3]);
    end
`ifdef SCR_MOVER_CHKSUM_EN
    vectors++;
    if (CHKSUM !== 10'h154) begin
      miscompares++;
      $display("[TB] FAIL fill_chksum got %h want 154", CHKSUM);
    end
`endif
  endtask

  task automatic test_copy;
    int busy_cyc = 0;
    logic [ADDR_W+DATA_W-1:0] e;
    ram[10] = 10'd1; ram[11] = 10'd2; ram[12] = 10'd3;
    ram[40] = '0; ram[41] = '0; ram[42] = '0;
    for (int i = 0; i < 3; i++) exp_q.push_back({8'd40 + 8'(i), 10'(i + 1)});
    start_op(1'b1, 8'd10, 8'd40, 8'd3, 10'h3FF);
    for (int c = 1; c <= 20; c++) begin
      if (!BUSY) break;
      busy_cyc++;
      if (SCR_WE) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL copy_extra_write got addr=%h din=%h want none", SCR_ADDR, SCR_DIN);
        end else begin
          e = exp_q.pop_front();
          if ({SCR_ADDR, SCR_DIN} !== e) begin
            miscompares++;
            $display("[TB] FAIL copy_write got %h/%h want %h/%h", SCR_ADDR, SCR_DIN, e[17:10], e[9:0]);
          end
        end
      end
      @(negedge CLK);
    end
    vectors++;
    if (busy_cyc != 7) begin
      miscompares++;
      $display("[TB] FAIL copy_busy_cycles got %0d want 7", busy_cyc);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL copy_missing_writes got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if ({ram[10], ram[11], ram[12]} !== {10'd1, 10'd2, 10'd3} ||
        {ram[40], ram[41], ram[42]} !== {10'd1, 10'd2, 10'd3}) begin
      miscompares++;
      $display("[TB] FAIL copy_ram got src=%h,%h,%h dst=%h,%h,%h want 1,2,3 both",
               ram[10], ram[11], ram[12], ram[40], ram[41], ram[42]);
    end
`ifdef SCR_MOVER_CHKSUM_EN
    vectors++;
    if (CHKSUM !== 10'd6) begin
      miscompares++;
      $display("[TB] FAIL copy_chksum got %h want 006", CHKSUM);
    end
`endif
  endtask

  task automatic test_wrap;
    int done_cyc = 0;
    logic [ADDR_W+DATA_W-1:0] e;
    exp_q.push_back({8'hFE, 10'h0A5});
    exp_q.push_back({8'hFF, 10'h0A5});
    exp_q.push_back({8'h00, 10'h0A5});
    start_op(1'b0, 8'h00, 8'hFE, 8'd3, 10'h0A5);
    for (int c = 1; c <= 20; c++) begin
      if (SCR_WE) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL wrap_extra_write got addr=%h want none", SCR_ADDR);
        end else begin
          e = exp_q.pop_front();
          if ({SCR_ADDR, SCR_DIN} !== e) begin
            miscompares++;
            $display("[TB] FAIL wrap_write got %h/%h want %h/%h", SCR_ADDR, SCR_DIN, e[17:10], e[9:0]);
          end
        end
      end
      if (DONE) begin done_cyc = c; break; end
      @(negedge CLK);
    end
    vectors++;
    if (done_cyc != 4 || exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL wrap_done got cycle=%0d left=%0d want 4/0", done_cyc, exp_q.size());
      exp_q.delete();
    end
    @(negedge CLK);
  endtask

  task automatic test_len_zero;
    logic [DATA_W-1:0] snap;
    snap = ram[8'h77];
    start_op(1'b0, 8'h00, 8'h77, 8'd0, 10'h111);
    vectors++;
    if ({BUSY, DONE, SCR_WE} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL len0_cycle1 got busy=%b done=%b we=%b want 1/1/0", BUSY, DONE, SCR_WE);
    end
    @(negedge CLK);
    vectors++;
    if ({BUSY, DONE, SCR_WE} !== 3'b000 || ram[8'h77] !== snap) begin
      miscompares++;
      $display("[TB] FAIL len0_after got busy=%b done=%b we=%b ram=%h want 0/0/0 ram=%h",
               BUSY, DONE, SCR_WE, ram[8'h77], snap);
    end
  endtask

  task automatic test_reset_mid_copy;
    int wr_seen = 0;
    int done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      ram[8'h60 + 8'(i)] = 10'h100 + 10'(i);
      ram[8'h80 + 8'(i)] = 10'h3FF;
    end
    start_op(1'b1, 8'h60, 8'h80, 8'd8, 10'h000);
    for (int c = 1; c <= 10 && wr_seen < 2; c++) begin
      if (SCR_WE) wr_seen++;
      @(negedge CLK);
    end
    #2 RST_N = 1'b0;
    #1;
    vectors++;
    if ({BUSY, DONE, SCR_WE, SCR_ADDR, SCR_DIN} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_async got busy=%b done=%b we=%b addr=%h din=%h want all 0",
               BUSY, DONE, SCR_WE, SCR_ADDR, SCR_DIN);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      if (DONE) done_seen++;
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_done got %0d pulses want 0", done_seen);
    end
    vectors++;
    if (ram[8'h80] !== 10'h100 || ram[8'h81] !== 10'h101 || ram[8'h82] !== 10'h3FF ||
        ram[8'h87] !== 10'h3FF) begin
      miscompares++;
      $display("[TB] FAIL midreset_ram got %h,%h,%h,%h want 100,101,3FF,3FF",
               ram[8'h80], ram[8'h81], ram[8'h82], ram[8'h87]);
    end
  endtask

  task automatic test_start_while_busy;
    int writes = 0;
    logic [ADDR_W+DATA_W-1:0] e;
    for (int i = 0; i < 3; i++) exp_q.push_back({8'h20 + 8'(i), 10'h0C3});
    start_op(1'b0, 8'h00, 8'h20, 8'd3, 10'h0C3);
    for (int c = 1; c <= 20; c++) begin
      START = 1'b0;
      if (SCR_WE) begin
        writes++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL busy_extra_write got addr=%h din=%h want none", SCR_ADDR, SCR_DIN);
        end else begin
          e = exp_q.pop_front();
          if ({SCR_ADDR, SCR_DIN} !== e) begin
            miscompares++;
            $display("[TB] FAIL busy_write got %h/%h want %h/%h", SCR_ADDR, SCR_DIN, e[17:10], e[9:0]);
          end
        end
      end
      // Competing requests: mid-fill and coincident with DONE.
      if (c == 2 || DONE) begin
        START = 1'b1; MODE = 1'b0; DST = 8'h50; LEN = 8'd5; FILL_VAL = 10'h3C3;
      end
      if (!BUSY && c > 1) break;
      @(negedge CLK);
    end
    START = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (SCR_WE) writes++;
    end
    vectors++;
    if (writes != 3 || exp_q.size() != 0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_ignore got writes=%0d left=%0d busy=%b want 3/0/0",
               writes, exp_q.size(), BUSY);
      exp_q.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    test_reset;
    test_fill;
    test_copy;
    test_wrap;
    test_len_zero;
    test_reset_mid_copy;
    test_start_while_busy;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
